mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
Main control state machine for the multi-cycle MIPS datapath. It sequences fetch, decode, execute, memory and write-back. It drives every datapath enable and mux select. It qualifies the PC write in branch states with the branch-condition flag produced by the branch unit. Memory accesses use a ready handshake guarded by a wait-timeout counter.

Parameters:
WAIT_MAX, 16, maximum cycles a memory state waits for mem_ready before aborting with bus_err
CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > WAIT_MAX

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
opcode  in  6  instr[31:26], from the IR
funct  in  6  instr[5:0], from the IR
bflag  in  1  branch-taken flag from the branch unit
mem_ready  in  1  memory completes the access this cycle
pc_write  out  1  PC load enable (already qualified with bflag in BR)
ir_write  out  1  IR load
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
iord  out  1  0 = address from PC, 1 = address from ALUOut
reg_write  out  1  register-file write
reg_dst  out  2  0 = rt, 1 = rd, 2 = $31
mem_to_reg  out  2  0 = ALUOut, 1 = MDR, 2 = PC (link)
alu_src_a  out  1  0 = PC, 1 = A
alu_src_b  out  2  0 = B, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm<<2
alu_op  out  2  0 = add, 1 = sub, 2 = decode funct, 3 = decode opcode (imm ops)
pc_src  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = A (jr)
instr_done  out  1  one-cycle pulse on the last cycle of each instruction
illegal  out  1  one-cycle pulse in ID on an unsupported opcode or funct
bus_err  out  1  one-cycle pulse when the wait counter reaches WAIT_MAX

Behaviour:
- States: IF, ID, EX_R, EX_I, ADDR, MRD, MWR, WB_MEM, WB_ALU, BR, JMP, JR.
- State register resets to IF. Wait counter resets to 0.
- While rst=1, all strobes and enables (pc_write, ir_write, mem_*, reg_write, instr_done, illegal, bus_err) are 0. Selects are don't-care.
- Outputs are Moore decodes of state, except:
  - pc_write in BR (bflag-qualified);
  - ir_write and pc_write in IF, which are gated by mem_ready.
- IF: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_src=0.
  - When mem_ready=1: ir_write=1, pc_write=1, go to ID.
  - Otherwise stay in IF.
- ID: alu_src_a=0, alu_src_b=3, alu_op=0 (precomputes the branch target into ALUOut). Dispatch on opcode:
  - 0 with funct 8: JR.
  - 0 with other supported funct: EX_R.
  - 1, 4, 5, 6, 7: BR.
  - 2, 3: JMP.
  - 8 to 15: EX_I.
  - 35, 43: ADDR.
  - Any other opcode or funct: illegal=1, instr_done=1, go to IF.
- EX_R: alu_src_a=1, alu_src_b=0, alu_op=2; go to WB_ALU with reg_dst=1.
- EX_I: alu_src_a=1, alu_src_b=2, alu_op=3; go to WB_ALU with reg_dst=0.
  - The WB_ALU reg_dst value is held in a 1-bit register captured on exit from EX_R/EX_I.
- WB_ALU: reg_write=1, mem_to_reg=0, instr_done=1; go to IF.
- ADDR: alu_src_a=1, alu_src_b=2, alu_op=0; opcode 35 goes to MRD, opcode 43 goes to MWR.
- MRD: mem_read=1, iord=1; go to WB_MEM on mem_ready.
- MWR: mem_write=1, iord=1; on mem_ready: instr_done=1, go to IF.
- WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1; go to IF.
- BR: alu_src_a=1, alu_src_b=0, alu_op=1, pc_src=1, pc_write=bflag, instr_done=1; go to IF.
- JMP: pc_src=2, pc_write=1, instr_done=1; go to IF.
  - For opcode 3 also: reg_write=1, reg_dst=2, mem_to_reg=2.
- JR: pc_src=3, pc_write=1, instr_done=1; go to IF.
- Zero-wait-state latencies: branch, jump and jr take 3 cycles; R-type, immediate and sw take 4; lw takes 5.
- Wait counter (IF, MRD, MWR):
  - Increments each cycle mem_ready=0.
  - Clears on state exit.
  - On reaching WAIT_MAX: bus_err=1, no strobe side effects, go to IF, counter cleared. The PC is not advanced.
- mem_ready=1 in the same cycle the counter reaches WAIT_MAX: ready wins, normal transition, no bus_err.
- rst asserted mid-instruction: next state is IF, and no write occurs in the reset cycle.

Decomposition:
- Shared package mc_pkg holds:
  - the state enum;
  - opcode and funct constants (OP_RTYPE=0, OP_REGIMM=1, OP_J=2, OP_JAL=3, OP_BEQ=4 … OP_LW=35, OP_SW=43, FN_JR=8);
  - the alu_src_b, alu_op, pc_src, reg_dst and mem_to_reg encodings.
- One natural sub-module, mc_wait_timer: the counter plus the timeout compare.

Test Plan:
- Reset, then lw (opcode 35) with mem_ready tied 1 → states IF, ID, ADDR, MRD, WB_MEM; reg_write=1 with mem_to_reg=1 in cycle 5; instr_done pulses once.
- beq (opcode 4) → in BR with bflag=1: pc_write=1, pc_src=1. Repeat with bflag=0 → pc_write=0. Both take 3 cycles.
- jal (opcode 3) → JMP with pc_write=1, reg_write=1, reg_dst=2, mem_to_reg=2; back in IF on cycle 4.
- IF with mem_ready held 0 for 16 cycles (WAIT_MAX=16) → bus_err pulses at the 16th, pc_write never asserted. Repeat with mem_ready=1 on the 16th cycle → ir_write=1, no bus_err.
- Opcode 63 → illegal=1 in ID, no writes, IF next cycle. R-type funct 8 → JR with pc_src=3.
- rst pulsed while in MWR with mem_ready=1 → mem_write=0 in that cycle, IF next cycle.

Source files
------------

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared states, opcode/funct constants and control encodings for mc_ctrl_fsm
package mc_pkg;

    typedef enum logic [3:0] {
        S_IF, S_ID, S_EX_R, S_EX_I, S_ADDR, S_MRD,
        S_MWR, S_WB_MEM, S_WB_ALU, S_BR, S_JMP, S_JR
    } state_e;

    localparam logic [5:0] OP_RTYPE  = 6'd0;
    localparam logic [5:0] OP_REGIMM = 6'd1;
    localparam logic [5:0] OP_J      = 6'd2;
    localparam logic [5:0] OP_JAL    = 6'd3;
    localparam logic [5:0] OP_BEQ    = 6'd4;
    localparam logic [5:0] OP_BNE    = 6'd5;
    localparam logic [5:0] OP_BLEZ   = 6'd6;
    localparam logic [5:0] OP_BGTZ   = 6'd7;
    localparam logic [5:0] OP_LW     = 6'd35;
    localparam logic [5:0] OP_SW     = 6'd43;
    localparam logic [5:0] FN_JR     = 6'd8;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_4      = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;
    localparam logic [1:0] ALU_IMM   = 2'd3;

    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;
    localparam logic [1:0] PCS_REG    = 2'd3;

    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MDR = 2'd1;
    localparam logic [1:0] M2R_PC  = 2'd2;

    // R-type functs executed through EX_R; jr is dispatched separately
    function automatic logic funct_supported(input logic [5:0] fn);
        logic ok;
        case (fn)
            6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7,
            6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39,
            6'd42, 6'd43: ok = 1'b1;
            default:      ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// rtl/mc_ctrl_fsm_if.sv - IR/flag inputs and datapath control bundle of the multi-cycle controller
interface mc_ctrl_fsm_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       bflag;
    logic       mem_ready;
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
    logic       illegal;
    logic       bus_err;

    modport master (
        input  opcode, funct, bflag, mem_ready,
        output pc_write, ir_write, mem_read, mem_write, iord, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
               instr_done, illegal, bus_err
    );

    modport slave (
        output opcode, funct, bflag, mem_ready,
        input  pc_write, ir_write, mem_read, mem_write, iord, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
               instr_done, illegal, bus_err
    );
endinterface

// File: rtl/mc_wait_timer.sv
// rtl/mc_wait_timer.sv - memory wait counter with timeout compare
module mc_wait_timer #(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ready,
    output logic timeout
);
    logic [CNT_W-1:0] cnt_q;

    // Counter holds the number of stalled cycles already spent, so this cycle is the WAIT_MAX-th
    assign timeout = active && !ready && (cnt_q == CNT_W'(WAIT_MAX - 1));

    always_ff @(posedge clk) begin
        if (rst || !active || ready || timeout) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - main control FSM of the multi-cycle MIPS datapath
module mc_ctrl_fsm
    import mc_pkg::*;
#(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic          clk,
    input  logic          rst,
    mc_ctrl_fsm_if.master bus
);
    state_e state_q, state_d;
    logic   rd_sel_q;
    logic   wait_active;
    logic   timeout;

    assign wait_active = (state_q == S_IF) || (state_q == S_MRD) || (state_q == S_MWR);

    mc_wait_timer #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .active  (wait_active),
        .ready   (bus.mem_ready),
        .timeout (timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IF;
            rd_sel_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_EX_R) rd_sel_q <= 1'b1;
            else if (state_q == S_EX_I) rd_sel_q <= 1'b0;
        end
    end

    always_comb begin
        state_d        = state_q;
        bus.pc_write   = 1'b0;
        bus.ir_write   = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.iord       = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = DST_RT;
        bus.mem_to_reg = M2R_ALU;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = SRCB_B;
        bus.alu_op     = ALU_ADD;
        bus.pc_src     = PCS_ALU;
        bus.instr_done = 1'b0;
        bus.illegal    = 1'b0;
        bus.bus_err    = 1'b0;
        case (state_q)
            S_IF: begin
                bus.alu_src_b = SRCB_4;
                if (timeout) begin
                    bus.bus_err = 1'b1;
                end else begin
                    bus.mem_read = 1'b1;
                    if (bus.mem_ready) begin
                        bus.ir_write = 1'b1;
                        bus.pc_write = 1'b1;
                        state_d      = S_ID;
                    end
                end
            end
            S_ID: begin
                bus.alu_src_b = SRCB_IMM_SH;
                case (bus.opcode)
                    OP_RTYPE: begin
                        if (bus.funct == FN_JR) begin
                            state_d = S_JR;
                        end else if (funct_supported(bus.funct)) begin
                            state_d = S_EX_R;
                        end else begin
                            bus.illegal    = 1'b1;
                            bus.instr_done = 1'b1;
                            state_d        = S_IF;
                        end
                    end
                    OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: state_d = S_BR;
                    OP_J, OP_JAL:                                state_d = S_JMP;
                    6'd8, 6'd9, 6'd10, 6'd11,
                    6'd12, 6'd13, 6'd14, 6'd15:                  state_d = S_EX_I;
                    OP_LW, OP_SW:                                state_d = S_ADDR;
                    default: begin
                        bus.illegal    = 1'b1;
                        bus.instr_done = 1'b1;
                        state_d        = S_IF;
                    end
                endcase
            end
            S_EX_R: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALU_FUNCT;
                state_d       = S_WB_ALU;
            end
            S_EX_I: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                bus.alu_op    = ALU_IMM;
                state_d       = S_WB_ALU;
            end
            S_WB_ALU: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = rd_sel_q ? DST_RD : DST_RT;
                bus.instr_done = 1'b1;
                state_d        = S_IF;
            end
            S_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                state_d       = (bus.opcode == OP_LW) ? S_MRD : S_MWR;
            end
            S_MRD: begin
                bus.iord = 1'b1;
                if (timeout) begin
                    bus.bus_err = 1'b1;
                    state_d     = S_IF;
                end else begin
                    bus.mem_read = 1'b1;
                    if (bus.mem_ready) state_d = S_WB_MEM;
                end
            end
            S_MWR: begin
                bus.iord = 1'b1;
                if (timeout) begin
                    bus.bus_err = 1'b1;
                    state_d     = S_IF;
                end else begin
                    bus.mem_write = 1'b1;
                    if (bus.mem_ready) begin
                        bus.instr_done = 1'b1;
                        state_d        = S_IF;
                    end
                end
            end
            S_WB_MEM: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = M2R_MDR;
                bus.instr_done = 1'b1;
                state_d        = S_IF;
            end
            S_BR: begin
                bus.alu_src_a  = 1'b1;
                bus.alu_op     = ALU_SUB;
                bus.pc_src     = PCS_ALUOUT;
                bus.pc_write   = bus.bflag;
                bus.instr_done = 1'b1;
                state_d        = S_IF;
            end
            S_JMP: begin
                bus.pc_src     = PCS_JUMP;
                bus.pc_write   = 1'b1;
                bus.instr_done = 1'b1;
                if (bus.opcode == OP_JAL) begin
                    bus.reg_write  = 1'b1;
                    bus.reg_dst    = DST_RA;
                    bus.mem_to_reg = M2R_PC;
                end
                state_d = S_IF;
            end
            S_JR: begin
                bus.pc_src     = PCS_REG;
                bus.pc_write   = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = S_IF;
            end
            default: state_d = S_IF;
        endcase
        // Reset cycle must not write anything, whatever state we were in
        if (rst) begin
            bus.pc_write   = 1'b0;
            bus.ir_write   = 1'b0;
            bus.mem_read   = 1'b0;
            bus.mem_write  = 1'b0;
            bus.reg_write  = 1'b0;
            bus.instr_done = 1'b0;
            bus.illegal    = 1'b0;
            bus.bus_err    = 1'b0;
            state_d        = S_IF;
        end
    end
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - self-checking bench for mc_ctrl_fsm against an instruction-level model
module tb_mc_ctrl_fsm;
    import mc_pkg::*;

    localparam int WAIT_MAX = 16;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       instr_done;
        logic       illegal;
        logic       bus_err;
    } ctl_t;

    typedef enum {T_IF, T_ID, T_EX_R, T_EX_I, T_ADDR, T_MRD, T_MWR,
                  T_WB_MEM, T_WB_ALU, T_BR, T_JMP, T_JR} step_e;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [5:0] cur_op;
    logic       cur_bf;
    logic       cur_ill;
    logic       ab;
    logic [5:0] rnd_ops [14] = '{6'd0, 6'd0, 6'd0, 6'd1, 6'd2, 6'd3, 6'd4,
                                 6'd5, 6'd8, 6'd12, 6'd15, 6'd35, 6'd43, 6'd43};
    logic [5:0] rnd_fns [6]  = '{6'd32, 6'd34, 6'd36, 6'd42, 6'd0, 6'd8};

    always #5 clk = ~clk;

    mc_ctrl_fsm_if bus ();

    mc_ctrl_fsm #(.WAIT_MAX(WAIT_MAX), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ctl_t observed();
        ctl_t o;
        o.pc_write   = bus.pc_write;
        o.ir_write   = bus.ir_write;
        o.mem_read   = bus.mem_read;
        o.mem_write  = bus.mem_write;
        o.iord       = bus.iord;
        o.reg_write  = bus.reg_write;
        o.reg_dst    = bus.reg_dst;
        o.mem_to_reg = bus.mem_to_reg;
        o.alu_src_a  = bus.alu_src_a;
        o.alu_src_b  = bus.alu_src_b;
        o.alu_op     = bus.alu_op;
        o.pc_src     = bus.pc_src;
        o.instr_done = bus.instr_done;
        o.illegal    = bus.illegal;
        o.bus_err    = bus.bus_err;
        return o;
    endfunction

    function automatic ctl_t strobe_mask();
        ctl_t c = '0;
        c.pc_write = 1'b1; c.ir_write = 1'b1; c.mem_read = 1'b1; c.mem_write = 1'b1;
        c.reg_write = 1'b1; c.instr_done = 1'b1; c.illegal = 1'b1; c.bus_err = 1'b1;
        return c;
    endfunction

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'd0)
            return fn inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd8, [6'd32:6'd39], 6'd42, 6'd43};
        return op inside {[6'd1:6'd15], 6'd35, 6'd43};
    endfunction

    task automatic cyc(input string tag, input ctl_t e, input ctl_t c, input logic rdy);
        bus.mem_ready = rdy;
        @(negedge clk);
        check(tag, 32'(observed() & c), 32'(e & c));
        @(posedge clk);
        #1;
    endtask

    // Expected controls of one cycle, taken straight from the per-step control table
    task automatic do_step(input step_e s, input logic rdy, input logic tmo, input logic rd);
        ctl_t e = '0;
        ctl_t c = strobe_mask();
        case (s)
            T_IF: begin
                if (tmo) e.bus_err = 1'b1;
                else begin
                    e.mem_read = 1'b1; e.ir_write = rdy; e.pc_write = rdy;
                    e.alu_src_b = 2'd1;
                    c.iord = 1'b1; c.alu_src_a = 1'b1; c.alu_src_b = '1; c.alu_op = '1; c.pc_src = '1;
                end
            end
            T_ID: begin
                e.alu_src_b = 2'd3; e.illegal = cur_ill; e.instr_done = cur_ill;
                c.alu_src_a = 1'b1; c.alu_src_b = '1; c.alu_op = '1;
            end
            T_EX_R: begin
                e.alu_src_a = 1'b1; e.alu_src_b = 2'd0; e.alu_op = 2'd2;
                c.alu_src_a = 1'b1; c.alu_src_b = '1; c.alu_op = '1;
            end
            T_EX_I: begin
                e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.alu_op = 2'd3;
                c.alu_src_a = 1'b1; c.alu_src_b = '1; c.alu_op = '1;
            end
            T_ADDR: begin
                e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.alu_op = 2'd0;
                c.alu_src_a = 1'b1; c.alu_src_b = '1; c.alu_op = '1;
            end
            T_WB_ALU: begin
                e.reg_write = 1'b1; e.instr_done = 1'b1; e.reg_dst = {1'b0, rd}; e.mem_to_reg = 2'd0;
                c.reg_dst = '1; c.mem_to_reg = '1;
            end
            T_MRD: begin
                if (tmo) e.bus_err = 1'b1;
                else begin e.mem_read = 1'b1; e.iord = 1'b1; c.iord = 1'b1; end
            end
            T_MWR: begin
                if (tmo) e.bus_err = 1'b1;
                else begin e.mem_write = 1'b1; e.instr_done = rdy; e.iord = 1'b1; c.iord = 1'b1; end
            end
            T_WB_MEM: begin
                e.reg_write = 1'b1; e.instr_done = 1'b1; e.reg_dst = 2'd0; e.mem_to_reg = 2'd1;
                c.reg_dst = '1; c.mem_to_reg = '1;
            end
            T_BR: begin
                e.alu_src_a = 1'b1; e.alu_src_b = 2'd0; e.alu_op = 2'd1; e.pc_src = 2'd1;
                e.pc_write = cur_bf; e.instr_done = 1'b1;
                c.alu_src_a = 1'b1; c.alu_src_b = '1; c.alu_op = '1; c.pc_src = '1;
            end
            T_JMP: begin
                e.pc_src = 2'd2; e.pc_write = 1'b1; e.instr_done = 1'b1; c.pc_src = '1;
                if (cur_op == 6'd3) begin
                    e.reg_write = 1'b1; e.reg_dst = 2'd2; e.mem_to_reg = 2'd2;
                    c.reg_dst = '1; c.mem_to_reg = '1;
                end
            end
            T_JR: begin
                e.pc_src = 2'd3; e.pc_write = 1'b1; e.instr_done = 1'b1; c.pc_src = '1;
            end
            default: ;
        endcase
        cyc(s.name(), e, c, rdy);
    endtask

    // A memory-waiting step: `waits` stalled cycles, aborted on the WAIT_MAX-th stall
    task automatic mem_phase(input step_e s, input int waits, output logic aborted);
        aborted = 1'b0;
        for (int k = 0; k < waits; k++) begin
            if (k == WAIT_MAX - 1) begin
                do_step(s, 1'b0, 1'b1, 1'b0);
                aborted = 1'b1;
                break;
            end
            do_step(s, 1'b0, 1'b0, 1'b0);
        end
        if (!aborted) do_step(s, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic bf,
                             input int if_wait, input int mem_wait);
        logic aborted;
        bus.opcode = op; bus.funct = fn; bus.bflag = bf;
        cur_op = op; cur_bf = bf; cur_ill = !is_legal(op, fn);
        mem_phase(T_IF, if_wait, aborted);
        if (aborted) return;
        do_step(T_ID, 1'($urandom), 1'b0, 1'b0);
        if (cur_ill) return;
        if (op == 6'd0 && fn == 6'd8) begin
            do_step(T_JR, 1'($urandom), 1'b0, 1'b0);
        end else if (op == 6'd0) begin
            do_step(T_EX_R, 1'($urandom), 1'b0, 1'b0);
            do_step(T_WB_ALU, 1'($urandom), 1'b0, 1'b1);
        end else if (op inside {6'd1, [6'd4:6'd7]}) begin
            do_step(T_BR, 1'($urandom), 1'b0, 1'b0);
        end else if (op inside {6'd2, 6'd3}) begin
            do_step(T_JMP, 1'($urandom), 1'b0, 1'b0);
        end else if (op inside {[6'd8:6'd15]}) begin
            do_step(T_EX_I, 1'($urandom), 1'b0, 1'b0);
            do_step(T_WB_ALU, 1'($urandom), 1'b0, 1'b0);
        end else if (op == 6'd35) begin
            do_step(T_ADDR, 1'($urandom), 1'b0, 1'b0);
            mem_phase(T_MRD, mem_wait, aborted);
            if (!aborted) do_step(T_WB_MEM, 1'($urandom), 1'b0, 1'b0);
        end else begin
            do_step(T_ADDR, 1'($urandom), 1'b0, 1'b0);
            mem_phase(T_MWR, mem_wait, aborted);
        end
    endtask

    function automatic int rnd_wait();
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(14, 18));
        return int'($urandom_range(0, 2));
    endfunction

    initial begin
        rst = 1'b1;
        bus.opcode = 6'd0; bus.funct = 6'd0; bus.bflag = 1'b0; bus.mem_ready = 1'b1;
        cyc("reset_0", '0, strobe_mask(), 1'b1);
        cyc("reset_1", '0, strobe_mask(), 1'b1);
        rst = 1'b0;

        run_instr(6'd35, 6'd0,  1'b0, 0, 0);    // lw
        run_instr(6'd4,  6'd0,  1'b1, 0, 0);    // beq taken
        run_instr(6'd4,  6'd0,  1'b0, 0, 0);    // beq not taken
        run_instr(6'd3,  6'd0,  1'b0, 0, 0);    // jal
        run_instr(6'd0,  6'd32, 1'b0, 0, 0);    // add
        run_instr(6'd8,  6'd0,  1'b0, 0, 0);    // addi
        run_instr(6'd43, 6'd0,  1'b0, 0, 0);    // sw
        run_instr(6'd2,  6'd0,  1'b0, 16, 0);   // fetch timeout
        run_instr(6'd2,  6'd0,  1'b0, 15, 0);   // ready on the last allowed cycle
        run_instr(6'd35, 6'd0,  1'b0, 0, 20);   // load timeout
        run_instr(6'd43, 6'd0,  1'b0, 2, 15);   // store, ready on the last allowed cycle
        run_instr(6'd63, 6'd0,  1'b0, 0, 0);    // illegal opcode
        run_instr(6'd0,  6'd1,  1'b0, 0, 0);    // illegal funct
        run_instr(6'd0,  6'd8,  1'b0, 0, 0);    // jr

        // reset lands while the store is in its memory cycle with ready high
        bus.opcode = 6'd43; bus.funct = 6'd0; cur_op = 6'd43; cur_bf = 1'b0; cur_ill = 1'b0;
        mem_phase(T_IF, 0, ab);
        do_step(T_ID, 1'b1, 1'b0, 1'b0);
        do_step(T_ADDR, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        cyc("rst_in_mwr", '0, strobe_mask(), 1'b1);
        rst = 1'b0;
        run_instr(6'd12, 6'd0, 1'b0, 0, 0);

        for (int n = 0; n < 120; n++) begin
            logic [5:0] op, fn;
            if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(0, 63));
            else op = rnd_ops[$urandom_range(0, 13)];
            if ($urandom_range(0, 5) == 0) fn = 6'($urandom_range(0, 63));
            else fn = rnd_fns[$urandom_range(0, 5)];
            run_instr(op, fn, 1'($urandom), rnd_wait(), rnd_wait());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
